// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU and writeback encodings plus the execute control bundle.
// Imported by the decoder, the issue unit and the bench.
package ctrl_pkg;

    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_MUL  = 8'h18;
    localparam logic [7:0] OP_ADDI = 8'h03;
    localparam logic [7:0] OP_SW   = 8'h19;
    localparam logic [7:0] OP_LW   = 8'h31;
    localparam logic [7:0] OP_JAL  = 8'h04;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_MUL = 4'b0010;

    localparam logic [1:0] MTR_MEM = 2'b00;
    localparam logic [1:0] MTR_ALU = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_src;
        logic [3:0] alu_op;
        logic       pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       rb_select;
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        SQUASH   = 2'd2
    } issue_state_t;

endpackage

// File: rtl/ctrl_issue_unit_if.sv
// Decode-slot inputs and execute-stage control outputs of the issue unit.
// The bench drives the master side; the issue unit is the slave.
interface ctrl_issue_unit_if #(
    parameter int OP_W  = 8,
    parameter int REG_W = 5
);
    logic             in_valid;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs_a;
    logic [REG_W-1:0] rs_b;
    logic [REG_W-1:0] rd;
    logic             stall;
    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic [1:0]       alu_src;
    logic [3:0]       alu_op;
    logic             pc_src;
    logic             mem_read;
    logic             mem_write;
    logic             rb_select;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             mul_busy;

    modport master (
        output in_valid, op, rs_a, rs_b, rd,
        input  stall, ex_valid, ex_rd, alu_src, alu_op, pc_src,
        input  mem_read, mem_write, rb_select, mem_to_reg,
        input  reg_write, mul_busy
    );

    modport slave (
        input  in_valid, op, rs_a, rs_b, rd,
        output stall, ex_valid, ex_rd, alu_src, alu_op, pc_src,
        output mem_read, mem_write, rb_select, mem_to_reg,
        output reg_write, mul_busy
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode to control-bundle decoder.
// Any opcode with nonzero bits above [7:0] falls through to NOP.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic [OP_W-1:0] op,
    output ctrl_bundle_t    ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            (op == OP_W'(OP_ADD)): begin
                ctrl.reg_write = 1'b1;
            end
            (op == OP_W'(OP_MUL)): begin
                ctrl.alu_op    = ALU_MUL;
                ctrl.reg_write = 1'b1;
            end
            (op == OP_W'(OP_ADDI)): begin
                ctrl.alu_src    = 2'b01;
                ctrl.mem_to_reg = MTR_ALU;
                ctrl.reg_write  = 1'b1;
            end
            (op == OP_W'(OP_SW)): begin
                ctrl.mem_write = 1'b1;
                ctrl.rb_select = 1'b1;
                ctrl.alu_src   = 2'b01;
            end
            (op == OP_W'(OP_LW)): begin
                ctrl.mem_read   = 1'b1;
                ctrl.rb_select  = 1'b1;
                ctrl.alu_src    = 2'b01;
                ctrl.mem_to_reg = MTR_MEM;
                ctrl.reg_write  = 1'b1;
            end
            (op == OP_W'(OP_JAL)): begin
                ctrl.pc_src     = 1'b1;
                ctrl.mem_to_reg = MTR_PC;
                ctrl.reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_issue_unit.sv
// Registered decode/issue stage: load-use interlock, multi-cycle MUL
// hold with late writeback, and JAL shadow-slot squashing.
module ctrl_issue_unit
    import ctrl_pkg::*;
#(
    parameter int OP_W      = 8,
    parameter int REG_W     = 5,
    parameter int MUL_LAT   = 3,
    parameter int JAL_SLOTS = 1
) (
    input logic clk,
    input logic rst,
    ctrl_issue_unit_if.slave bus
);

    issue_state_t     state, state_n;
    logic [3:0]       cnt, cnt_n;
    ctrl_bundle_t     dec, b_q, b_n;
    logic             v_q, v_n;
    logic             busy_q, busy_n;
    logic [REG_W-1:0] rd_q, rd_n;
    logic             hazard, issue, is_mul, is_jal;

    ctrl_decode #(.OP_W(OP_W)) u_dec (
        .op   (bus.op),
        .ctrl (dec)
    );

    assign hazard = v_q && b_q.mem_read && (rd_q != '0) && bus.in_valid
                 && ((bus.rs_a == rd_q) || (bus.rs_b == rd_q));
    assign issue  = (state == RUN) && bus.in_valid && !hazard;
    assign is_mul = issue && (dec.alu_op == ALU_MUL);
    assign is_jal = issue && dec.pc_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            RUN: begin
                if (is_mul && MUL_LAT > 1) begin
                    state_n = MUL_WAIT;
                    cnt_n   = 4'(MUL_LAT - 1);
                end else if (is_jal && JAL_SLOTS > 0) begin
                    state_n = SQUASH;
                    cnt_n   = 4'(JAL_SLOTS);
                end
            end
            MUL_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RUN;
            end
            SQUASH: begin
                if (bus.in_valid) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // Defaults describe a bubble; ex_rd is retained across bubbles.
    always_comb begin
        v_n    = 1'b0;
        b_n    = '0;
        rd_n   = rd_q;
        busy_n = 1'b0;
        unique case (state)
            RUN: begin
                if (issue) begin
                    v_n  = 1'b1;
                    b_n  = dec;
                    rd_n = bus.rd;
                    if (is_mul && MUL_LAT > 1) begin
                        b_n.reg_write = 1'b0;
                        busy_n        = 1'b1;
                    end
                end
            end
            MUL_WAIT: begin
                v_n = 1'b1;
                b_n = b_q;
                if (cnt == 4'd1) b_n.reg_write = 1'b1;
                else busy_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            b_q    <= '0;
            rd_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            v_q    <= v_n;
            b_q    <= b_n;
            rd_q   <= rd_n;
            busy_q <= busy_n;
        end
    end

    assign bus.stall      = !rst && ((state == MUL_WAIT) || (state == RUN && hazard));
    assign bus.ex_valid   = v_q;
    assign bus.ex_rd      = rd_q;
    assign bus.alu_src    = b_q.alu_src;
    assign bus.alu_op     = b_q.alu_op;
    assign bus.pc_src     = b_q.pc_src;
    assign bus.mem_read   = b_q.mem_read;
    assign bus.mem_write  = b_q.mem_write;
    assign bus.rb_select  = b_q.rb_select;
    assign bus.mem_to_reg = b_q.mem_to_reg;
    assign bus.reg_write  = b_q.reg_write;
    assign bus.mul_busy   = busy_q;

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Directed bench for ctrl_issue_unit with MUL_LAT=3, JAL_SLOTS=1.
// Outputs are checked 1 time unit after each rising edge.
module tb_ctrl_issue_unit;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    ctrl_issue_unit_if #(.OP_W(8), .REG_W(5)) bus ();

    ctrl_issue_unit #(
        .OP_W(8), .REG_W(5), .MUL_LAT(3), .JAL_SLOTS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {ex_valid, alu_src, alu_op, pc_src, mem_read, mem_write,
    //  rb_select, mem_to_reg, reg_write, mul_busy}
    localparam logic [14:0] E_BUB  = 15'b0_00_0000_0_0_0_0_00_0_0;
    localparam logic [14:0] E_NOP  = 15'b1_00_0000_0_0_0_0_00_0_0;
    localparam logic [14:0] E_ADD  = 15'b1_00_0000_0_0_0_0_00_1_0;
    localparam logic [14:0] E_ADDI = 15'b1_01_0000_0_0_0_0_01_1_0;
    localparam logic [14:0] E_LW   = 15'b1_01_0000_0_1_0_1_00_1_0;
    localparam logic [14:0] E_SW   = 15'b1_01_0000_0_0_1_1_00_0_0;
    localparam logic [14:0] E_JAL  = 15'b1_00_0000_1_0_0_0_10_1_0;
    localparam logic [14:0] E_MUL0 = 15'b1_00_0010_0_0_0_0_00_0_1;
    localparam logic [14:0] E_MULF = 15'b1_00_0010_0_0_0_0_00_1_0;

    function automatic logic [14:0] obs();
        return {bus.ex_valid, bus.alu_src, bus.alu_op, bus.pc_src,
                bus.mem_read, bus.mem_write, bus.rb_select,
                bus.mem_to_reg, bus.reg_write, bus.mul_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] o,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        bus.in_valid = v;
        bus.op       = o;
        bus.rs_a     = a;
        bus.rs_b     = b;
        bus.rd       = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
        chk("rst_stall", 32'(bus.stall), 0);
        tick();
        tick();
        chk("rst_bundle", 32'(obs()), 32'(E_BUB));
        chk("rst_rd", 32'(bus.ex_rd), 0);

        rst = 1'b0;
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
        chk("add_stall", 32'(bus.stall), 0);
        tick();
        chk("add_bundle", 32'(obs()), 32'(E_ADD));
        chk("add_rd", 32'(bus.ex_rd), 3);

        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd5);
        chk("lw_stall", 32'(bus.stall), 0);
        tick();
        chk("lw_bundle", 32'(obs()), 32'(E_LW));
        chk("lw_rd", 32'(bus.ex_rd), 5);
        drive(1'b1, OP_ADD, 5'd5, 5'd1, 5'd6);
        chk("lu_stall", 32'(bus.stall), 1);
        tick();
        chk("lu_bubble", 32'(obs()), 32'(E_BUB));
        chk("lu_rd_kept", 32'(bus.ex_rd), 5);
        chk("lu_stall_once", 32'(bus.stall), 0);
        tick();
        chk("lu_add", 32'(obs()), 32'(E_ADD));
        chk("lu_add_rd", 32'(bus.ex_rd), 6);

        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd0);
        tick();
        chk("lw0_bundle", 32'(obs()), 32'(E_LW));
        drive(1'b1, OP_ADD, 5'd0, 5'd0, 5'd7);
        chk("rd0_nostall", 32'(bus.stall), 0);
        tick();
        chk("rd0_add", 32'(obs()), 32'(E_ADD));

        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd9);
        tick();
        drive(1'b1, OP_ADD, 5'd9, 5'd9, 5'd10);
        chk("both_stall", 32'(bus.stall), 1);
        tick();
        chk("both_bubble", 32'(obs()), 32'(E_BUB));
        chk("both_stall_once", 32'(bus.stall), 0);
        tick();
        chk("both_add", 32'(obs()), 32'(E_ADD));

        drive(1'b1, OP_SW, 5'd1, 5'd2, 5'd12);
        tick();
        chk("sw_bundle", 32'(obs()), 32'(E_SW));

        drive(1'b1, OP_MUL, 5'd1, 5'd2, 5'd4);
        chk("mul_stall0", 32'(bus.stall), 0);
        tick();
        chk("mul_c1", 32'(obs()), 32'(E_MUL0));
        drive(1'b1, OP_ADD, 5'd4, 5'd1, 5'd8);
        chk("mul_stall1", 32'(bus.stall), 1);
        tick();
        chk("mul_c2", 32'(obs()), 32'(E_MUL0));
        chk("mul_rd", 32'(bus.ex_rd), 4);
        chk("mul_stall2", 32'(bus.stall), 1);
        tick();
        chk("mul_c3", 32'(obs()), 32'(E_MULF));
        chk("mul_stall3", 32'(bus.stall), 0);
        tick();
        chk("mul_add", 32'(obs()), 32'(E_ADD));
        chk("mul_add_rd", 32'(bus.ex_rd), 8);

        drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1);
        tick();
        chk("jal_bundle", 32'(obs()), 32'(E_JAL));
        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd5);
        chk("sq_stall", 32'(bus.stall), 0);
        tick();
        chk("sq_lw_bubble", 32'(obs()), 32'(E_BUB));
        chk("sq_rd_kept", 32'(bus.ex_rd), 1);
        drive(1'b1, OP_ADD, 5'd5, 5'd5, 5'd2);
        chk("sq_no_lu", 32'(bus.stall), 0);
        tick();
        chk("sq_add", 32'(obs()), 32'(E_ADD));

        drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1);
        tick();
        chk("jal2_bundle", 32'(obs()), 32'(E_JAL));
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 5'd9);
        tick();
        chk("gap_bubble", 32'(obs()), 32'(E_BUB));
        drive(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd3);
        tick();
        chk("sq_addi_bubble", 32'(obs()), 32'(E_BUB));
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd2);
        tick();
        chk("gap_add", 32'(obs()), 32'(E_ADD));

        drive(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd13);
        tick();
        chk("addi_bundle", 32'(obs()), 32'(E_ADDI));

        drive(1'b1, OP_MUL, 5'd1, 5'd2, 5'd4);
        tick();
        chk("rmul_c1", 32'(obs()), 32'(E_MUL0));
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd6);
        tick();
        chk("rmul_c2", 32'(obs()), 32'(E_MUL0));
        chk("rmul_stall", 32'(bus.stall), 1);
        rst = 1'b1;
        #1;
        chk("rmul_rst_stall", 32'(bus.stall), 0);
        tick();
        chk("rmul_rst_bundle", 32'(obs()), 32'(E_BUB));
        chk("rmul_rst_rd", 32'(bus.ex_rd), 0);
        rst = 1'b0;
        drive(1'b1, 8'hFF, 5'd1, 5'd2, 5'd11);
        chk("nop_stall", 32'(bus.stall), 0);
        tick();
        chk("nop_bundle", 32'(obs()), 32'(E_NOP));
        chk("nop_rd", 32'(bus.ex_rd), 11);
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 5'd14);
        chk("post_rst_run", 32'(bus.stall), 0);
        tick();
        chk("post_rst_add", 32'(obs()), 32'(E_ADD));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
